// File: rtl/pp_batch_accumulator.sv
// rtl/pp_batch_accumulator.sv - sums fixed batches of N_PP aligned partial products (optional ACC_ZERO_FLAG_EN adds o_zero)
module pp_batch_accumulator #(
    parameter int PP_W  = 15,
    parameter int N_PP  = 8,
    parameter int EXP_W = 6,
    parameter int Q_W   = 5,
    localparam int SUM_W = PP_W + $clog2(N_PP)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [PP_W-1:0]  i_align_pp,
    input  logic [EXP_W-1:0] i_max_exp,
    input  logic [Q_W-1:0]   i_Q_frac,
    input  logic             i_flush,
    output logic             o_valid,
    output logic [SUM_W-1:0] o_sum,
    output logic [EXP_W-1:0] o_exp,
    output logic [Q_W-1:0]   o_Q_frac,
`ifdef ACC_ZERO_FLAG_EN
    output logic             o_zero,
`endif
    output logic             o_busy
);

    localparam int CNT_W = $clog2(N_PP);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PP - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count, count_n;
    logic [SUM_W-1:0]   acc, acc_n;
    logic [EXP_W-1:0]   batch_exp, batch_exp_n;
    logic [Q_W-1:0]     batch_q, batch_q_n;
    logic [SUM_W-1:0]   pp_ext, sum_in;
    logic               valid_n;
    logic [SUM_W-1:0]   sum_n;
    logic [EXP_W-1:0]   exp_n;
    logic [Q_W-1:0]     q_n;

    // The batch phase is fully implied by the beat count.
    assign state  = (count == '0) ? IDLE : ACCUM;
    assign pp_ext = {{(SUM_W-PP_W){i_align_pp[PP_W-1]}}, i_align_pp};
    assign sum_in = acc + pp_ext;

    always_comb begin
        acc_n       = acc;
        count_n     = count;
        batch_exp_n = batch_exp;
        batch_q_n   = batch_q;
        valid_n     = 1'b0;
        sum_n       = o_sum;
        exp_n       = o_exp;
        q_n         = o_Q_frac;
        if (i_flush) begin
            // Flush beats any same-cycle beat, including a would-be last one.
            acc_n   = '0;
            count_n = '0;
        end else if (i_valid) begin
            case (state)
                IDLE: begin
                    acc_n       = pp_ext;
                    batch_exp_n = i_max_exp;
                    batch_q_n   = i_Q_frac;
                    count_n     = CNT_W'(1);
                end
                ACCUM: begin
                    if (count == LAST) begin
                        sum_n   = sum_in;
                        exp_n   = batch_exp;
                        q_n     = batch_q;
                        valid_n = 1'b1;
                        acc_n   = '0;
                        count_n = '0;
                    end else begin
                        acc_n   = sum_in;
                        count_n = count + CNT_W'(1);
                    end
                end
                default: begin
                    acc_n   = '0;
                    count_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc       <= '0;
            count     <= '0;
            batch_exp <= '0;
            batch_q   <= '0;
            o_valid   <= 1'b0;
            o_sum     <= '0;
            o_exp     <= '0;
            o_Q_frac  <= '0;
            o_busy    <= 1'b0;
        end else begin
            acc       <= acc_n;
            count     <= count_n;
            batch_exp <= batch_exp_n;
            batch_q   <= batch_q_n;
            o_valid   <= valid_n;
            o_sum     <= sum_n;
            o_exp     <= exp_n;
            o_Q_frac  <= q_n;
            o_busy    <= (count_n != '0);
        end
    end

`ifdef ACC_ZERO_FLAG_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_zero <= 1'b0;
        end else if (valid_n) begin
            o_zero <= (sum_n == '0);
        end
    end
`endif

endmodule

// File: tb/tb_pp_batch_accumulator.sv
// tb/tb_pp_batch_accumulator.sv - scoreboard bench for pp_batch_accumulator
module tb_pp_batch_accumulator;

    localparam int PP_W  = 15;
    localparam int N_PP  = 8;
    localparam int EXP_W = 6;
    localparam int Q_W   = 5;
    localparam int SUM_W = PP_W + $clog2(N_PP);

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_valid = 1'b0;
    logic [PP_W-1:0]  i_align_pp = '0;
    logic [EXP_W-1:0] i_max_exp = '0;
    logic [Q_W-1:0]   i_Q_frac = '0;
    logic             i_flush = 1'b0;
    logic             o_valid;
    logic [SUM_W-1:0] o_sum;
    logic [EXP_W-1:0] o_exp;
    logic [Q_W-1:0]   o_Q_frac;
    logic             o_busy;
`ifdef ACC_ZERO_FLAG_EN
    logic             o_zero;
`endif

    pp_batch_accumulator #(.PP_W(PP_W), .N_PP(N_PP), .EXP_W(EXP_W), .Q_W(Q_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_align_pp(i_align_pp),
        .i_max_exp(i_max_exp), .i_Q_frac(i_Q_frac), .i_flush(i_flush),
        .o_valid(o_valid), .o_sum(o_sum), .o_exp(o_exp), .o_Q_frac(o_Q_frac),
`ifdef ACC_ZERO_FLAG_EN
        .o_zero(o_zero),
`endif
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [SUM_W-1:0] s;
        logic [EXP_W-1:0] e;
        logic [Q_W-1:0]   q;
        logic             z;
    } exp_t;

    exp_t             sb[$];
    int               batch[$];
    logic [EXP_W-1:0] b_exp;
    logic [Q_W-1:0]   b_q;
    exp_t             last = '0;
    int               checks = 0;
    int               errors = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: a batch is just a list of signed products; the result is their plain sum.
    task automatic step(input bit v, input logic [PP_W-1:0] pp, input logic [EXP_W-1:0] e,
                        input logic [Q_W-1:0] q, input bit fl, input bit rs);
        int total;
        exp_t x;
        i_valid = v; i_align_pp = pp; i_max_exp = e; i_Q_frac = q; i_flush = fl; i_rst = rs;
        @(posedge i_clk);
        if (rs) begin
            batch.delete();
            last = '0;
        end else if (fl) begin
            batch.delete();
        end else if (v) begin
            batch.push_back(int'($signed(pp)));
            if (batch.size() == 1) begin
                b_exp = e;
                b_q = q;
            end
            if (batch.size() == N_PP) begin
                total = 0;
                foreach (batch[k]) total += batch[k];
                x.s = SUM_W'(total);
                x.e = b_exp;
                x.q = b_q;
                x.z = (total == 0);
                sb.push_back(x);
                batch.delete();
            end
        end
        #1;
        check("busy", o_busy, batch.size() != 0);
        if (rs) begin
            check("rst_valid", o_valid, 0);
            check("rst_sum", o_sum, 0);
            check("rst_exp", o_exp, 0);
            check("rst_q", o_Q_frac, 0);
        end
    endtask

    task automatic beats(input int n, input logic [PP_W-1:0] pp, input logic [EXP_W-1:0] e,
                         input logic [Q_W-1:0] q);
        for (int i = 0; i < n; i++) step(1, pp, e, q, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, 0);
    endtask

    always @(negedge i_clk) begin
        exp_t x;
        if (o_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                x = sb.pop_front();
                check("sum", o_sum, x.s);
                check("exp", o_exp, x.e);
                check("q_frac", o_Q_frac, x.q);
`ifdef ACC_ZERO_FLAG_EN
                check("zero", o_zero, x.z);
`endif
                last = x;
            end
        end else begin
            if (sb.size() != 0) begin
                check("missing_valid", 0, 1);
                void'(sb.pop_front());
            end
            check("sum_hold", o_sum, last.s);
            check("exp_hold", o_exp, last.e);
        end
    end

    initial begin
        step(0, '0, '0, '0, 0, 1);
        step(0, '0, '0, '0, 0, 1);
        idle(1);
        beats(8, 15'h0001, 6'd20, 5'd3);
        idle(2);
        beats(8, 15'h3FFF, 6'd11, 5'd7);
        beats(8, 15'h4001, 6'd12, 5'd8);
        idle(1);
        beats(1, 15'h0005, 6'd30, 5'd1);
        beats(3, 15'h0005, 6'd9, 5'd2);
        idle(3);
        beats(4, 15'h0005, 6'd9, 5'd2);
        idle(1);
        beats(5, 15'h0009, 6'd4, 5'd4);
        step(1, 15'h0009, 6'd4, 5'd4, 1, 0);
        idle(1);
        beats(8, 15'h0002, 6'd5, 5'd5);
        idle(1);
        step(1, 15'h0011, 6'd1, 5'd1, 1, 0);
        beats(6, 15'h0003, 6'd2, 5'd2);
        step(1, 15'h0003, 6'd2, 5'd2, 0, 1);
        beats(8, 15'h7FFF, 6'd33, 5'd9);
        idle(1);
        beats(4, 15'h0003, 6'd7, 5'd6);
        beats(4, 15'h7FFD, 6'd7, 5'd6);
        beats(8, 15'h0001, 6'd8, 5'd7);
        beats(7, 15'h0001, 6'd8, 5'd7);
        step(1, 15'h0001, 6'd8, 5'd7, 1, 0);
        idle(1);
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            step(r < 70, PP_W'($urandom), EXP_W'($urandom), Q_W'($urandom), r == 98, r == 99);
        end
        idle(3);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pp_batch_accumulator.md
Name: pp_batch_accumulator

Overview:
- Downstream stage of the partial-product alignment pipeline.
- Consumes one sign-extended, exponent-aligned partial product per valid cycle and sums a fixed batch of N_PP products into a wider two's-complement result.
- Forwards the batch's shared max exponent and Q_frac to the normalisation stage.
- Supports back-to-back batches with no bubble, plus a flush to abandon a partial batch.

Parameters:
- PP_W, 15, width of incoming aligned partial product (two's complement).
- N_PP, 8, products per batch (>=2).
- SUM_W, PP_W+$clog2(N_PP), output sum width; derived, never overridden.
- EXP_W, 6, exponent width.
- Q_W, 5, Q_frac width.

Ports:
- i_clk  input  1  clock, all logic on rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_valid  input  1  align_pp/i_max_exp/i_Q_frac valid this cycle.
- i_align_pp  input  PP_W  aligned signed partial product.
- i_max_exp  input  EXP_W  batch max exponent (sampled on first beat only).
- i_Q_frac  input  Q_W  batch Q_frac (sampled on first beat only).
- i_flush  input  1  discard the batch in progress.
- o_valid  output  1  one-cycle pulse: o_sum/o_exp/o_Q_frac hold a finished batch.
- o_sum  output  SUM_W  signed sum of the N_PP products.
- o_exp  output  EXP_W  max exponent of the finished batch.
- o_Q_frac  output  Q_W  Q_frac of the finished batch.
- o_busy  output  1  high while a batch is partially accumulated (count != 0).

Behaviour:
- Reset: reset is synchronous and active-high on i_rst; the block has one clock, i_clk. Reset clears acc, count, o_valid, o_sum, o_exp, o_Q_frac and o_busy to 0. Reset wins over every other input. Reset mid-batch drops the partial batch silently.
- State: count in 0..N_PP-1 and acc (SUM_W). Two states are implied by count: IDLE (count==0) and ACCUM (count>0). o_busy = (count!=0), registered.
- Sign extension: each i_align_pp is sign-extended from PP_W to SUM_W before adding. SUM_W is wide enough that overflow is impossible, so there is no saturation or wrap in normal operation.
- First beat (i_valid and count==0): acc <= sext(pp); capture i_max_exp and i_Q_frac into batch registers; count <= 1.
- Middle beat (i_valid and 0<count<N_PP-1): acc <= acc+sext(pp); count++. i_max_exp and i_Q_frac are ignored.
- Last beat (i_valid and count==N_PP-1):
  - o_sum <= acc+sext(pp).
  - o_exp and o_Q_frac <= captured batch values.
  - o_valid <= 1; count <= 0; acc <= 0.
  - Latency is 1 cycle from the last-beat edge to o_valid.
- Back-to-back: a first beat of the next batch in the cycle after the last beat is accepted normally.
- Idle cycles (i_valid=0) inside a batch hold acc and count. A batch may be spread over any number of cycles.
- o_valid is a single-cycle pulse. o_sum, o_exp and o_Q_frac hold their values until the next o_valid.
- Flush: i_flush=1 sets count <= 0 and acc <= 0. Any beat in the same cycle is discarded, including a would-be last beat, so no o_valid is produced. Output registers are untouched. Flush in IDLE is a no-op.
- N_PP==2 is the boundary case: every beat alternates first/last.

Optional Feature:
- Macro: ACC_ZERO_FLAG_EN.
- When defined: an extra output port o_zero (1 bit) exists. It is registered with o_sum, equals (sum==0), resets to 0, and is valid whenever o_valid pulses; otherwise it holds.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then 8 consecutive beats of pp=15'h0001, max_exp=6'd20, Q_frac=5'd3 -> o_valid one cycle after 8th beat; o_sum=18'h00008, o_exp=20, o_Q_frac=3; o_busy low after.
- 8 beats of pp=15'h3FFF -> o_sum=18'h1FFF8. Then 8 beats of pp=15'h4001 (-16383) -> o_sum=18'h20008. Back-to-back with no bubble; o_valid on two cycles exactly 8 apart.
- 4 beats of pp=15'h0005, then 3 idle cycles, then 4 more beats -> o_sum=18'h00028. max_exp changed to 9 on beat 2 -> o_exp still the beat-1 value.
- 5 beats then i_flush together with a valid beat, then 8 beats of 15'h0002 -> exactly one o_valid, o_sum=18'h00010. o_sum keeps its previous value until then.
- i_rst asserted at beat 7 of a batch, then 8 beats of 15'h7FFF (-1) -> all outputs 0 during reset, then o_sum=18'h3FFF8.
- ACC_ZERO_FLAG_EN defined: 4×15'h0003 + 4×15'h7FFD -> o_sum=0 with o_zero=1. Next batch of 8×15'h0001 -> o_zero=0.
